stopwatch_bcd: RTL

Millisecond stopwatch that consumes the one-cycle tick produced by the 1000-count divider stage (one pulse every 1000 `clk` cycles, i.e. 1 ms at 1 MHz). It accumulates ticks into a BCD time value MM:SS.mmm, under start/stop, lap and clear controls. The digits feed the display driver stage downstream.

---
 rtl/stopwatch_bcd_pkg.sv | 28 ++
 rtl/stopwatch_bcd_digit.sv | 24 ++
 rtl/stopwatch_bcd.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_bcd_pkg.sv
// Shared types, digit limits and the BCD increment helper for the stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LAP,
        PAUSE
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t MS_LIM    = 4'd9;
    localparam bcd_t SEC_U_LIM = 4'd9;
    localparam bcd_t SEC_T_LIM = 4'd5;
    localparam bcd_t MIN_U_MAX = 4'd9;

    // Value a digit takes after this edge: wraps to zero once it has reached its limit.
    function automatic bcd_t bcdNext(input bcd_t q, input logic inc, input bcd_t limit);
        bcd_t result;
        result = q;
        if (inc) begin
            result = (q == limit) ? 4'd0 : q + 4'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One cascadable BCD counter digit with a run-time limit and combinational carry-out.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  bcd_t limit,
    output bcd_t q,
    output logic carry
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= 4'd0;
        end else begin
            q <= bcdNext(q, inc, limit);
        end
    end

    assign carry = inc && (q == limit);

endmodule

// File: rtl/stopwatch_bcd.sv
// Millisecond stopwatch MM:SS.mmm in BCD with run/pause, lap freeze and clear.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int MIN_LIMIT = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic [3:0] ms_h,
    output logic [3:0] ms_t,
    output logic [3:0] ms_u,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    localparam bcd_t MIN_T_LIM = bcd_t'(MIN_LIMIT / 10);
    localparam bcd_t MIN_U_TOP = bcd_t'(MIN_LIMIT % 10);

    sw_state_t state;

    logic tickEn;
    logic holdDisplay;

    bcd_t msUQ, msTQ, msHQ, secUQ, secTQ, minUQ, minTQ;
    logic msUCarry, msTCarry, msHCarry, secUCarry, secTCarry, minUCarry, wrapCarry;
    bcd_t minULimit;

    // Ticks only count in the counting states; a tick alongside clear is dropped.
    assign tickEn = tick_in && ((state == RUN) || (state == LAP)) && !clear;

    // The minutes units wrap early only when the tens digit sits at the top decade.
    assign minULimit = (minTQ == MIN_T_LIM) ? MIN_U_TOP : MIN_U_MAX;

    bcd_digit uMsU (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .inc  (tickEn),
        .limit(MS_LIM),
        .q    (msUQ),
        .carry(msUCarry)
    );

    bcd_digit uMsT (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .inc  (msUCarry),
        .limit(MS_LIM),
        .q    (msTQ),
        .carry(msTCarry)
    );

    bcd_digit uMsH (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .inc  (msTCarry),
        .limit(MS_LIM),
        .q    (msHQ),
        .carry(msHCarry)
    );

    bcd_digit uSecU (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .inc  (msHCarry),
        .limit(SEC_U_LIM),
        .q    (secUQ),
        .carry(secUCarry)
    );

    bcd_digit uSecT (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .inc  (secUCarry),
        .limit(SEC_T_LIM),
        .q    (secTQ),
        .carry(secTCarry)
    );

    bcd_digit uMinU (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .inc  (secTCarry),
        .limit(minULimit),
        .q    (minUQ),
        .carry(minUCarry)
    );

    bcd_digit uMinT (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .inc  (minUCarry),
        .limit(MIN_T_LIM),
        .q    (minTQ),
        .carry(wrapCarry)
    );

    // Control FSM; running/lap_active are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state      <= IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_stop) begin
                        state      <= RUN;
                        running    <= 1'b1;
                        lap_active <= 1'b0;
                    end
                end
                RUN: begin
                    if (start_stop) begin
                        state      <= PAUSE;
                        running    <= 1'b0;
                        lap_active <= 1'b0;
                    end else if (lap) begin
                        state      <= LAP;
                        running    <= 1'b1;
                        lap_active <= 1'b1;
                    end
                end
                LAP: begin
                    if (start_stop) begin
                        state      <= PAUSE;
                        running    <= 1'b0;
                        lap_active <= 1'b0;
                    end else if (lap) begin
                        state      <= RUN;
                        running    <= 1'b1;
                        lap_active <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (start_stop) begin
                        state      <= RUN;
                        running    <= 1'b1;
                        lap_active <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    running    <= 1'b0;
                    lap_active <= 1'b0;
                end
            endcase
        end
    end

    // Display freezes only while the FSM stays in LAP across this edge.
    assign holdDisplay = (state == LAP) && !start_stop && !lap;

    // The display loads the post-edge live value, so a tick on lap entry lands in the snapshot.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            min_t <= 4'd0;
            min_u <= 4'd0;
            sec_t <= 4'd0;
            sec_u <= 4'd0;
            ms_h  <= 4'd0;
            ms_t  <= 4'd0;
            ms_u  <= 4'd0;
        end else if (!holdDisplay) begin
            min_t <= bcdNext(minTQ, minUCarry, MIN_T_LIM);
            min_u <= bcdNext(minUQ, secTCarry, minULimit);
            sec_t <= bcdNext(secTQ, secUCarry, SEC_T_LIM);
            sec_u <= bcdNext(secUQ, msHCarry, SEC_U_LIM);
            ms_h  <= bcdNext(msHQ, msTCarry, MS_LIM);
            ms_t  <= bcdNext(msTQ, msUCarry, MS_LIM);
            ms_u  <= bcdNext(msUQ, tickEn, MS_LIM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            overflow <= 1'b0;
        end else if (wrapCarry) begin
            overflow <= 1'b1;
        end
    end

endmodule
